// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared state encoding, default widths and helpers for the fifo_reader block.
package fifo_reader_pkg;

    localparam int FIFO_WL    = 8;
    localparam int FIFO_LEN_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE,
        ABORT
    } state_t;

    // Width of a counter that has to reach the value 'timeout'.
    function automatic int stall_cnt_w(input int timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/fifo_reader_oreg.sv
// fifo_reader_oreg: registered valid/ready output stage; holds its word until the consumer accepts it.
module fifo_reader_oreg
    import fifo_reader_pkg::*;
#(
    parameter int wL = FIFO_WL
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic          clear,
    input  logic [wL-1:0] load_data,
    input  logic          load_last,
    input  logic          out_ready,
    output logic [wL-1:0] out_data,
    output logic          out_valid,
    output logic          out_last
);

    // NOTE: out_data is reset as well, so a word in flight when reset hits is
    // discarded rather than reappearing once the block restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (clear) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_valid <= 1'b1;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: drains a programmed-length burst from a show-ahead FIFO into a valid/ready stream.
// Define FIFO_READER_TIMEOUT_EN to add the stall watchdog and the ABORT completion path.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int wL      = FIFO_WL,
    parameter int LEN_W   = FIFO_LEN_W,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic [wL-1:0]    fifo_data_pop,
    input  logic             fifo_empty,
    input  logic             fifo_almost_empty,
    output logic             fifo_pop,
    output logic [wL-1:0]    out_data,
    output logic             out_valid,
    output logic             out_last,
    input  logic             out_ready
);

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic             pop_q;
    logic             pop;
    logic             abort_now;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifo_reader: TIMEOUT must be at least 1");
    end

    // pop_q covers the flags still showing one word right after we took it.
    assign pop = (state == RUN) && (remaining != '0) && !fifo_empty
               && !(pop_q && fifo_almost_empty) && (!out_valid || out_ready);
    assign fifo_pop = pop;

`ifdef FIFO_READER_TIMEOUT_EN
    localparam int STALL_W = stall_cnt_w(TIMEOUT);

    logic [STALL_W-1:0] stall_cnt;

    assign abort_now = (state == RUN) && !pop && (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            err <= abort_now;
            if (state != RUN || pop || abort_now) begin
                stall_cnt <= '0;
            end else begin
                stall_cnt <= stall_cnt + STALL_W'(1);
            end
        end
    end
`else
    assign abort_now = 1'b0;
    assign err       = 1'b0;
`endif

    // NOTE: state and registered outputs use non-blocking assignments so every
    // branch reads pre-edge values, matching the flops it describes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            remaining <= '0;
            pop_q     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pop_q <= pop;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        remaining <= len;
                        if (len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (pop) begin
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            state <= DRAIN;
                        end
                    end
`ifdef FIFO_READER_TIMEOUT_EN
                    else if (abort_now) begin
                        state <= ABORT;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
`endif
                end
                DRAIN: begin
                    if (out_valid && out_ready && out_last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                // DONE and ABORT each last exactly one cycle.
                default: state <= IDLE;
            endcase
        end
    end

    fifo_reader_oreg #(.wL(wL)) u_oreg (
        .clk       (clk),
        .rst       (rst),
        .load      (pop),
        .clear     (abort_now),
        .load_data (fifo_data_pop),
        .load_last (remaining == LEN_W'(1)),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last)
    );

endmodule

// File: doc/fifo_reader.md
# fifo_reader

Pop-side controller for the team's synchronous FIFO (show-ahead read data, registered full/empty/almost flags). On a `start` command it drains a programmed number of words from the FIFO and forwards them to a downstream valid/ready consumer through a registered output stage, marking the final word and signalling completion. It sits between a FIFO's pop port and any block that consumes bursts.

## Interface
- `wL`, default 8: data word width; matches the FIFO's `wL`.
- `LEN_W`, default 8: burst length field width.
- `TIMEOUT`, default 255: stall limit in cycles; used only with the watchdog macro.

Ports:
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle request to begin a burst; honoured only in IDLE.
- `len` in LEN_W: word count, sampled with `start`.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: qualifies `done`; high means the burst was aborted.
- `fifo_data_pop` in wL: FIFO head word, combinational, valid while FIFO non-empty.
- `fifo_empty` in 1: FIFO registered empty flag.
- `fifo_almost_empty` in 1: FIFO registered one-left flag.
- `fifo_pop` out 1: pop strobe to the FIFO.
- `out_data` out wL: registered output word.
- `out_valid` out 1: output word valid.
- `out_last` out 1: qualifies `out_valid`; final word of the burst.
- `out_ready` in 1: downstream accept.

## Operation
- States: IDLE, RUN, DRAIN, DONE, plus ABORT when the watchdog is compiled in.
- IDLE: on `start`, latch `len` into `remaining`. If `len`==0, go to DONE, which pulses `done` with no pops. Otherwise go to RUN.
- RUN: `fifo_pop` = `remaining`!=0 AND `fifo_empty`==0 AND NOT(`fifo_pop` was high last cycle AND `fifo_almost_empty`==1) AND (`out_valid`==0 OR `out_ready`==1). The guard term covers the one-cycle lag of the FIFO flags.
- Each pop loads `out_data` <= `fifo_data_pop`, sets `out_valid`, and decrements `remaining`. `out_last` is set when `remaining` was 1.
- The pop that makes `remaining` reach 0 moves the block to DRAIN.
- DRAIN: hold until the last word is accepted (`out_valid`&&`out_ready`&&`out_last`), then go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- Output stage: `out_data`, `out_valid`, and `out_last` stay stable while `out_valid`=1 and `out_ready`=0. `out_valid` clears on accept with no new pop.
- `start` outside IDLE is ignored; `len` is not re-sampled.
- Reset mid-burst: immediate return to IDLE. The output word is discarded and FIFO contents are untouched.
- Arithmetic: `remaining` is LEN_W bits and decrements only on pop, so it never underflows. Maximum burst is 2^LEN_W-1.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `fifo_pop`=0, `out_data`=0, `out_valid`=0, `out_last`=0. State resets to IDLE.
- `start` to first `fifo_pop`: 1 cycle minimum, taken in RUN.
- `fifo_pop` to `out_valid`: the word appears at the same edge that advances the FIFO read pointer, i.e. 1-cycle latency.
- Throughput: one word per cycle while the FIFO is non-empty and `out_ready`=1.
- `done` follows the last accept by exactly 1 cycle.
- `busy` falls in the same cycle that `done` rises.

## Configuration
- `FIFO_READER_TIMEOUT_EN` defined:
  - A stall counter clears on every pop and increments in RUN while no pop occurs.
  - When the counter reaches `TIMEOUT`, the block enters ABORT. ABORT drops `out_valid` and pulses `done` with `err`=1 for one cycle, then returns to IDLE.
  - The counter is held at 0 outside RUN.
- Macro undefined: no counter and no ABORT state, and `err` is tied to 0. RUN waits indefinitely.

## Structure
- `fifo_reader_pkg` holds:
  - the `state_t` enum (IDLE, RUN, DRAIN, DONE, ABORT);
  - default constants `FIFO_WL`=8 and `FIFO_LEN_W`=8;
  - the timeout counter width function.
- Sub-module `fifo_reader_oreg` is the registered output stage. It takes a load strobe and the data/last inputs, and produces `out_data`, `out_valid`, and `out_last` from `out_ready`.
- The state machine and `remaining` counter live in the top.

## Test plan
- Reset, then `len`=0 with `start` → `done`=1 one cycle later, `err`=0, zero `fifo_pop` pulses.
- FIFO preloaded 0x11..0x14, `len`=4, `out_ready`=1 → four back-to-back outputs 0x11,0x12,0x13,0x14, `out_last` on 0x14, `done` 1 cycle after.
- Same burst with `out_ready` toggling 1,0,0,1 → `out_data` held stable while stalled, no extra pops, order preserved.
- FIFO holds 1 word (`fifo_almost_empty`=1), `len`=3 → exactly one pop, then none until the FIFO refills. The next word is 0x22 after a push, and no duplicate 0x21 is emitted.
- `rst` asserted mid-burst after 2 of 5 words → all outputs return to reset values immediately. A new `start` with `len`=3 pops the next three FIFO words.
- With `FIFO_READER_TIMEOUT_EN` and `TIMEOUT`=8, FIFO empty, `len`=2 → `done`=1 with `err`=1 eight cycles after the last pop opportunity.
